// File: rtl/logic_op_sweeper_pkg.sv
// ============================================================================
// Module : logic_op_pkg
// Brief  : Opcodes, golden model and FSM encoding for the logic-op sweeper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package logic_op_pkg;

  localparam logic [1:0] OP_AND   = 2'b00;
  localparam logic [1:0] OP_OR    = 2'b01;
  localparam logic [1:0] OP_XOR   = 2'b10;
  localparam logic [1:0] OP_NOT_A = 2'b11;

  typedef logic [15:0] result_map_t;
  typedef logic [4:0]  err_count_t;

  // Every vector can mismatch, so the count must reach 16.
  localparam err_count_t ERR_MAX = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic logic_op_eval(input logic a, input logic b, input logic [1:0] c);
    logic r;
    case (c)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~a;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/logic_op_sweeper_if.sv
// ============================================================================
// Module : logic_op_sweeper_if
// Brief  : Stimulus/result bundle between the sweeper and its environment.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface logic_op_sweeper_if;
  import logic_op_pkg::*;

  logic        start;
  logic        y;
  logic        a;
  logic        b;
  logic [1:0]  c;
  logic        busy;
  logic        done;
  logic        valid;
  result_map_t results;
  err_count_t  err_count;
  logic        pass;

  modport master (
    output start, y,
    input  a, b, c, busy, done, valid, results, err_count, pass
  );

  modport slave (
    input  start, y,
    output a, b, c, busy, done, valid, results, err_count, pass
  );

endinterface

`default_nettype wire

// File: rtl/logic_op_sweeper.sv
// ============================================================================
// Module : logic_op_sweeper
// Brief  : Drives all 16 {c,a,b} vectors into a logic-op unit and scores y.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module logic_op_sweeper
  import logic_op_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  logic_op_sweeper_if.slave   bus
);

  localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e      state_q,   state_d;
  logic [3:0]  idx_q,     idx_d;
  logic [7:0]  cnt_q,     cnt_d;
  result_map_t results_q, results_d;
  err_count_t  err_q,     err_d;
  logic        valid_q,   valid_d;
  logic        done_q,    done_d;
  logic        busy_q,    busy_d;
  logic        a_q,       a_d;
  logic        b_q,       b_d;
  logic [1:0]  c_q,       c_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      cnt_q     <= 8'd0;
      results_q <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      c_q       <= 2'b00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      results_q <= results_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    results_d = results_q;
    err_d     = err_q;
    valid_d   = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_DRIVE;
          idx_d     = 4'd0;
          cnt_d     = 8'd0;
          results_d = '0;
          err_d     = '0;
          valid_d   = 1'b0;
        end
      end
      ST_DRIVE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == c_HOLD_LAST) begin
          cnt_d            = 8'd0;
          results_d[idx_q] = bus.y;
          if ((bus.y != logic_op_eval(idx_q[1], idx_q[0], idx_q[3:2])) && (err_q != ERR_MAX)) begin
            err_d = err_q + 5'd1;
          end
          if (idx_q == 4'hF) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they land in registers.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    a_d    = (state_d == ST_DRIVE) & idx_d[1];
    b_d    = (state_d == ST_DRIVE) & idx_d[0];
    c_d    = (state_d == ST_DRIVE) ? idx_d[3:2] : 2'b00;
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.c         = c_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.valid     = valid_q;
  assign bus.results   = results_q;
  assign bus.err_count = err_q;
  assign bus.pass      = valid_q && (err_q == '0);

endmodule

`default_nettype wire

// File: doc/logic_op_sweeper.md
# logic_op_sweeper

- Self-checking stimulus and capture stage for the 2-input logic-operation unit in the lab designs.
- Upstream role: on `start`, drives every combination of opcode `c[1:0]` and operands `a`, `b` into the unit, holding each vector for a programmable number of cycles.
- Downstream role: samples the unit's `y` for each vector and compares it with a built-in golden model.
- Reports a 16-bit result map, an error count and a pass flag for on-board LEDs or a bench.

## Interface

Parameters:
- `HOLD_CYCLES`, default 4: cycles each vector is held before `y` is sampled. Legal range 1..255.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep. Sampled only in IDLE.
- `y`  in  1  result from the logic-operation unit.
- `a`  out  1  operand A to the unit.
- `b`  out  1  operand B to the unit.
- `c`  out  2  opcode to the unit.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `valid`  out  1  level: `results`, `err_count` and `pass` hold a complete sweep.
- `results`  out  16  captured `y`; bit index = {c,a,b}.
- `err_count`  out  5  number of mismatches against the golden model, 0..16.
- `pass`  out  1  `valid && err_count==0`.

## Operation

**Vector order**
- 4-bit index `idx`, counting 0..15.
- `c = idx[3:2]`, `a = idx[1]`, `b = idx[0]`.

**Golden model**

| `c` | expected |
|---|---|
| 00 | `a&b` |
| 01 | `a\|b` |
| 10 | `a^b` |
| 11 | `~a` |

**FSM states**
- IDLE
  - `a`, `b`, `c` driven 0.
  - `start=1` → DRIVE. Same edge: `idx=0`, `cnt=0`, `err_count=0`, `results=0`, `valid=0`.
- DRIVE
  - Outputs reflect `idx`; `cnt` increments each cycle.
  - On the edge where `cnt==HOLD_CYCLES-1`:
    - `results[idx] <= y`.
    - `err_count` increments if `y` ≠ expected.
    - `cnt <= 0`.
    - If `idx==15` → DONE, otherwise `idx` increments.
- DONE
  - Lasts exactly one cycle.
  - `done=1` and `valid` set; next state is IDLE.

**Outputs by state**
- `busy` is high in DRIVE and DONE, low in IDLE.
- `a`, `b`, `c` return to 0 in DONE and IDLE.

**Boundary conditions**
- `start` is ignored while in DRIVE or DONE. If `start` is held high, a new sweep begins in the first IDLE cycle after DONE.
- A new sweep clears `valid`, `results` and `err_count` at the start edge.
- `err_count` saturates at 16; 16 is reachable, so 5 bits are required.
- `rst_n` low at any time, including mid-sweep, immediately forces IDLE.

**Reset values (all outputs)**
- `a=0`, `b=0`, `c=00`.
- `busy=0`, `done=0`, `valid=0`, `pass=0`.
- `results=16'h0000`, `err_count=0`.
- Internal `idx=0`, `cnt=0`.

## Timing

- Cycle 0 is the edge where `start=1` is sampled in IDLE.
- Vector `k` is driven during cycles `1+k*HOLD_CYCLES` .. `k*HOLD_CYCLES+HOLD_CYCLES`. Its `y` is sampled at the last of those edges.
- `done` is high in cycle `1+16*HOLD_CYCLES`; `valid` is high from the following cycle.
- The unit under sweep is combinational, so `HOLD_CYCLES=1` is legal. Larger values tolerate registered or slow downstream paths.
- All outputs are registered. `pass` may be a combinational AND of two registers.
- `cnt` width is 8 bits.

## Structure

Shared package `logic_op_pkg` contains:
- Opcode constants `OP_AND=2'b00`, `OP_OR=2'b01`, `OP_XOR=2'b10`, `OP_NOT_A=2'b11`.
- Function `logic_op_eval(a,b,c)` implementing the golden model.
- FSM state encoding: IDLE, DRIVE, DONE.

No sub-module is needed. The FSM, hold counter, index and scoreboard are one module.

## Test plan

1. Reference-correct unit on `y`, `HOLD_CYCLES=4`, pulse `start` → `done` pulse at cycle 65; `results=16'h36E8`, `err_count=0`, `pass=1`.
2. `y` tied 0, `HOLD_CYCLES=4` → `results=16'h0000`, `err_count=8`, `pass=0`.
3. `y` tied 1, `HOLD_CYCLES=1` → `done` at cycle 17; `results=16'hFFFF`, `err_count=8`.
4. Assert `rst_n=0` at cycle 20 of a sweep → `busy`, `a`, `b`, `c`, `results`, `err_count` and `valid` all 0 the same cycle. Releasing reset and pulsing `start` yields `16'h36E8`.
5. Pulse `start` at cycle 10 mid-sweep → ignored; `done` still at cycle 65 with one `done` pulse only.
6. `start` held high continuously → back-to-back sweeps. `valid` is high for one cycle between them, then cleared at the next start edge. Each `done` is separated by `16*HOLD_CYCLES+2` cycles.
